// File: rtl/cbsel_arb_if.sv
// Request/data/grant bundle between the requesters and the cbsel round-robin arbiter.
interface cbsel_arb_if #(
    parameter int WIDTH = 10
);
    logic [3:0]       req;
    logic [WIDTH-1:0] i0;
    logic [WIDTH-1:0] i1;
    logic [WIDTH-1:0] i2;
    logic [WIDTH-1:0] i3;
    logic [3:0]       d;
    logic [1:0]       owner;
    logic [WIDTH-1:0] o;
    logic             o_valid;

    modport master (
        output req, i0, i1, i2, i3,
        input  d, owner, o, o_valid
    );

    modport slave (
        input  req, i0, i1, i2, i3,
        output d, owner, o, o_valid
    );
endinterface

// File: rtl/cbsel_arb.sv
// Round-robin arbiter driving the one-hot select of a four-input cbsel and
// registering the selected word; bounded bursts, no idle bubble on handoff.
module cbsel_arb #(
    parameter int WIDTH    = 10,
    parameter int MAX_HOLD = 4
) (
    input logic        clk,
    input logic        rst,
    cbsel_arb_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [1:0]       last_reg, last_next;
    logic [3:0]       d_reg, d_next;
    logic [1:0]       owner_reg, owner_next;
    logic [WIDTH-1:0] o_reg, o_next;
    logic             o_valid_reg, o_valid_next;

    logic [WIDTH-1:0] in_word [4];
    logic [3:0]       owner_onehot;
    logic [3:0]       others;
    logic [2:0]       pick_idle;
    logic [2:0]       pick_hand;
    logic             owner_req;
    logic             release_cond;

    // Returns {found, index} of the first set bit of mask scanning start, start+1, ... mod 4.
    function automatic logic [2:0] rr_pick(input logic [3:0] mask, input logic [1:0] start);
        logic [2:0] r;
        logic [1:0] idx;
        r = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (mask[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    assign in_word[0] = bus.i0;
    assign in_word[1] = bus.i1;
    assign in_word[2] = bus.i2;
    assign in_word[3] = bus.i3;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_owner_dec
            assign owner_onehot[gi] = (owner_reg == 2'(gi));
        end
    endgenerate

    assign others       = bus.req & ~owner_onehot;
    assign owner_req    = bus.req[owner_reg];
    assign pick_idle    = rr_pick(bus.req, last_reg + 2'd1);
    assign pick_hand    = rr_pick(others, owner_reg + 2'd1);
    // Forced release only when someone else is actually waiting; a sole requester keeps the bus.
    assign release_cond = !owner_req || ((cnt_reg == CNT_MAX) && (others != 4'b0000));

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        last_next    = last_reg;
        d_next       = d_reg;
        owner_next   = owner_reg;
        o_next       = o_reg;
        o_valid_next = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (bus.req != 4'b0000) begin
                    d_next     = onehot(pick_idle[1:0]);
                    owner_next = pick_idle[1:0];
                    cnt_next   = CNT_W'(1);
                    state_next = GRANT;
                end
            end
            GRANT: begin
                if (owner_req) begin
                    o_next       = in_word[owner_reg];
                    o_valid_next = 1'b1;
                end
                if (release_cond) begin
                    last_next = owner_reg;
                    if (pick_hand[2]) begin
                        d_next     = onehot(pick_hand[1:0]);
                        owner_next = pick_hand[1:0];
                        cnt_next   = CNT_W'(1);
                    end else begin
                        d_next     = 4'b0000;
                        state_next = IDLE;
                    end
                end else if (cnt_reg != CNT_MAX) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            last_reg    <= 2'd3;
            d_reg       <= 4'b0000;
            owner_reg   <= 2'd0;
            o_reg       <= '0;
            o_valid_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            last_reg    <= last_next;
            d_reg       <= d_next;
            owner_reg   <= owner_next;
            o_reg       <= o_next;
            o_valid_reg <= o_valid_next;
        end
    end

    assign bus.d       = d_reg;
    assign bus.owner   = owner_reg;
    assign bus.o       = o_reg;
    assign bus.o_valid = o_valid_reg;
endmodule

// File: doc/cbsel_arb.md
# cbsel_arb

Round-robin arbiter that shares the four-input one-hot data selector (`cbsel`) between four requesters. It generates the one-hot select `d[3:0]` that drives the `cbsel` select port and registers the selected 10-bit word with a valid flag. A grant is held while its requester keeps requesting, up to a bounded burst. Rotation is fair, and there is no idle bubble when ownership changes hands.

## Interface

Parameters:
- `WIDTH`, 10, data width of each input and of `o`.
- `MAX_HOLD`, 4, maximum consecutive grant cycles while another requester is waiting (≥1).

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  4  request per requester; bit n belongs to `in`.
- `i0`, `i1`, `i2`, `i3`  in  WIDTH  requester data words.
- `d`  out  4  registered one-hot grant; 0000 = no grant; drives the `cbsel` select.
- `owner`  out  2  registered index of the current grantee; valid when `d`≠0.
- `o`  out  WIDTH  registered data of the grantee.
- `o_valid`  out  1  registered; `o` holds a word captured this cycle.

## Operation

- State `state` ∈ {IDLE, GRANT}. Internal registers:
  - `cnt`: 0..MAX_HOLD, saturating.
  - `last`: 2 bits, last grantee.
- Round-robin search from index s: check s, s+1, s+2, s+3 (mod 4) against the candidate mask. The first set bit wins.
- IDLE, at each edge:
  - `o_valid`←0 and `o` holds its value.
  - If `req`≠0, search `req` from `last`+1. Then `d`←onehot(win), `owner`←win, `cnt`←1, state←GRANT.
  - Otherwise `d` stays 0000.
- GRANT, at each edge, data capture:
  - If `req[owner]`=1: `o`←i[owner], `o_valid`←1.
  - Otherwise `o_valid`←0 and `o` holds.
- GRANT, at each edge, release condition R is true when either:
  - `req[owner]`=0, or
  - `cnt`=MAX_HOLD and (`req` & ~onehot(owner))≠0.
- GRANT, when R is true:
  - `last`←owner.
  - Search `req` & ~onehot(owner) from `owner`+1.
  - If a winner exists: `d`←onehot(win), `owner`←win, `cnt`←1, stay in GRANT. There is no IDLE cycle between owners.
  - If no winner: `d`←0000, state←IDLE.
- GRANT, when R is false:
  - `cnt`←min(`cnt`+1, MAX_HOLD).
  - A sole requester therefore holds the grant indefinitely, and its `cnt` saturates.
- `d` is always 0000 or exactly one bit set. `owner` always matches `d` when `d`≠0.
- `req` changes on non-owner bits do not disturb the current grant until the release condition R is evaluated.

## Timing

- Reset values: `d`=0000, `owner`=0, `o`=0, `o_valid`=0, state=IDLE, `cnt`=0, `last`=3. With `last`=3, the first search after reset starts at index 0.
- Reset mid-GRANT: at the next edge all registers take their reset values, and any pending requests are ignored on that edge. Arbitration restarts from index 0 after `rst` deasserts.
- Latency from `req` to `d`: a request sampled at edge k gives `d` asserted after edge k.
- Latency from `d` to `o`: data is sampled at edge k+1, so `o` and `o_valid` are asserted after edge k+1.
- Handoff without a bubble: with release at edge k, the new `d` is asserted after edge k and the new owner's data appears after edge k+1.
  - If release was caused by a dropped request, `o_valid` is 0 for the cycle after edge k.
  - If release was forced by `MAX_HOLD`, `o_valid` stays high through the handoff.
- Burst bound: with other requesters waiting, an owner receives at most MAX_HOLD consecutive valid words.
- Worst-case wait for a requester: 3·MAX_HOLD cycles from its `req` being sampled to its grant.

## Test plan

- Single requester: after reset, `req`=0001, `i0`=18. Required: `d`=0001 one cycle later, then `o`=18 with `o_valid`=1, held while `req` is held.
- Solo hold: `req`=1000 for 10 cycles, `i3`=140. Required: `d` stays 1000 throughout, no rotation, `o`=140 and `o_valid`=1 for 9 consecutive cycles.
- All requesting, MAX_HOLD=4: `req`=1111 with `i0..i3`=18, 12, 15, 140. Required:
  - `d` sequence 0001×4, 0010×4, 0100×4, 1000×4, then 0001 again.
  - `o` follows one cycle behind `d`, with `o_valid` continuously 1.
- Owner drop: `req`=0110 and owner is 1; drop bit 1 at edge k. Required: `d`=0100 after edge k, `o_valid`=0 for one cycle, then `o`=`i2`=15.
- All drop: during a grant, set `req`=0000. Required: `d`=0000 and state IDLE after the next edge, `o_valid`=0, `o` keeps its last value.
- Reset mid-grant: `rst`=1 for one edge while `d`=0010 and `req`=1100. Required: `d`=0000, `o`=0, `o_valid`=0 after that edge; after release, grant goes to index 2 first (`d`=0100).
